mem_arbiter: RTL

- Sequences the single shared multi-cycle main memory between the instruction-cache miss path and the data-cache miss/write path of the pipelined 16-bit CPU.
- Performs 8-word line fills for either cache, and single-word write-through stores for the data side.
- Drives the pipeline-wide mem_ready: low while any memory operation is in flight.
- Sits between the cache controllers and the main memory model.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between the I-cache and D-cache miss paths.
// Performs 8-word line fills for either cache and single-word D-side write-through stores.
module mem_arbiter #(
    parameter int WORDS_PER_LINE = 8,
    parameter int CNT_W          = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_valid,
    output logic        fill_valid,
    output logic        fill_sel,
    output logic [2:0]  fill_idx,
    output logic [15:0] fill_data,
    output logic        i_done,
    output logic        d_done,
    output logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, I_FILL, D_FILL, D_WRITE} state_t;

    localparam logic [CNT_W:0]   LINE_WORDS = (CNT_W+1)'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WORDS_PER_LINE - 1);

    state_t           state_q, state_d;
    logic [CNT_W:0]   issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] rcv_cnt_q, rcv_cnt_d;
    logic             last_grant_q, last_grant_d;   // 1 = D side
    logic             hold_q, hold_d;
    logic [15:0]      base_q, base_d;
    logic             grant_d_side;
    logic             in_fill;
    logic             last_word;

    assign in_fill   = (state_q == I_FILL) || (state_q == D_FILL);
    assign last_word = in_fill && mem_valid && (rcv_cnt_q == LAST_IDX);
    assign mem_ready = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            issue_cnt_q  <= '0;
            rcv_cnt_q    <= '0;
            last_grant_q <= 1'b0;
            hold_q       <= 1'b0;
            base_q       <= '0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            rcv_cnt_q    <= rcv_cnt_d;
            last_grant_q <= last_grant_d;
            hold_q       <= hold_d;
            base_q       <= base_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        rcv_cnt_d    = rcv_cnt_q;
        last_grant_d = last_grant_q;
        hold_d       = 1'b0;
        base_d       = base_q;
        grant_d_side = 1'b0;
        case (state_q)
            IDLE: begin
                // hold_q keeps IDLE for one extra cycle after each completion
                if (!hold_q && (i_req || d_req)) begin
                    grant_d_side = d_req && (!i_req || !last_grant_q);
                    last_grant_d = grant_d_side;
                    base_d       = (grant_d_side ? d_addr : i_addr) & 16'hFFF0;
                    issue_cnt_d  = '0;
                    rcv_cnt_d    = '0;
                    if (grant_d_side) begin
                        state_d = d_wr ? D_WRITE : D_FILL;
                    end else begin
                        state_d = I_FILL;
                    end
                end
            end
            I_FILL, D_FILL: begin
                if (issue_cnt_q < LINE_WORDS) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (mem_valid) begin
                    rcv_cnt_d = rcv_cnt_q + 1'b1;
                end
                if (last_word) begin
                    state_d     = IDLE;
                    issue_cnt_d = '0;
                    rcv_cnt_d   = '0;
                    hold_d      = 1'b1;
                end
            end
            D_WRITE: begin
                state_d = IDLE;
                hold_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_sel   = 1'b0;
        fill_idx   = '0;
        fill_data  = '0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        if (in_fill) begin
            if (issue_cnt_q < LINE_WORDS) begin
                mem_en   = 1'b1;
                mem_addr = base_q + 16'({issue_cnt_q[CNT_W-1:0], 1'b0});
            end
            if (mem_valid) begin
                fill_valid = 1'b1;
                fill_sel   = (state_q == D_FILL);
                fill_idx   = 3'(rcv_cnt_q);
                fill_data  = mem_rdata;
            end
            i_done = last_word && (state_q == I_FILL);
            d_done = last_word && (state_q == D_FILL);
        end else if (state_q == D_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            d_done    = 1'b1;
        end
    end

endmodule
